// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, arbiter state encoding and the hard-wired zero register index
// for the register-file write arbiter.
package regfile_write_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_NREGS  = 32;
    localparam int REG_ZERO  = 0;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_reg_scoreboard.sv
// Pending-destination scoreboard for MDU results: one bit per register, set on
// accepted issue, cleared on MDU writeback, with a three-operand hazard lookup.
module reg_scoreboard
    import regfile_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREGS  = RF_NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic              issue_ready,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_reg,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    output logic              hazard,
    input  logic [ADDR_W-1:0] probe_reg,
    output logic              probe_pending
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic             clearing_same;
    logic             set;

    function automatic logic owed(input logic [NREGS-1:0] v, input logic [ADDR_W-1:0] r);
        return (r != ADDR_W'(REG_ZERO)) && v[r];
    endfunction

    // A register being written back this cycle may be re-issued in the same
    // cycle; the new set then overrides the clear.
    assign clearing_same = clr && (clr_reg == issue_reg);
    assign issue_ready   = issue_valid && (!rst_n || !pending[issue_reg] || clearing_same);
    assign set           = rst_n && issue_ready && (issue_reg != ADDR_W'(REG_ZERO));

    always_comb begin
        pending_next = pending;
        if (clr) begin
            pending_next[clr_reg] = 1'b0;
        end
        if (set) begin
            pending_next[issue_reg] = 1'b1;
        end
        pending_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign hazard        = rst_n && (owed(pending, rs) || owed(pending, rt) || owed(pending, rd));
    assign probe_pending = pending[probe_reg];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single regfile write port between WB (priority) and the MDU, with
// a starvation counter that forces an MDU grant; write path is 0-cycle combinational.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W,
    parameter int NREGS    = RF_NREGS,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_reg,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] dec_rs,
    input  logic [ADDR_W-1:0] dec_rt,
    input  logic [ADDR_W-1:0] dec_rd,
    output logic              hazard_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wreg,
    output logic [DATA_W-1:0] rf_wdata
);

    arb_state_t state;
    arb_state_t state_next;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_next;
    logic       grant_wb;
    logic       mdu_pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB_NORMAL;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        grant_wb      = 1'b0;
        mdu_ready     = 1'b0;
        wb_stall      = 1'b0;
        if (rst_n) begin
            case (state)
                ARB_NORMAL: begin
                    grant_wb  = wb_we;
                    mdu_ready = mdu_valid && !wb_we;
                end
                ARB_FORCE: begin
                    mdu_ready = mdu_valid;
                    wb_stall  = wb_we;
                end
                default: ;
            endcase
        end

        // The count tracks consecutive refusals of the result currently offered.
        if (mdu_ready || !mdu_valid) begin
            wait_cnt_next = '0;
        end else if (wait_cnt != 4'(MAX_WAIT)) begin
            wait_cnt_next = wait_cnt + 4'd1;
        end

        case (state)
            ARB_NORMAL: if (wait_cnt_next == 4'(MAX_WAIT)) state_next = ARB_FORCE;
            ARB_FORCE:  if (mdu_ready || !mdu_valid) state_next = ARB_NORMAL;
            default:    state_next = ARB_NORMAL;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_wreg  = '0;
        rf_wdata = '0;
        if (grant_wb) begin
            rf_we    = (wb_reg != ADDR_W'(REG_ZERO));
            rf_wreg  = wb_reg;
            rf_wdata = wb_data;
        end else if (mdu_ready) begin
            rf_we    = (mdu_reg != ADDR_W'(REG_ZERO));
            rf_wreg  = mdu_reg;
            rf_wdata = mdu_data;
        end
    end

    reg_scoreboard #(
        .ADDR_W(ADDR_W),
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_reg    (issue_reg),
        .issue_ready  (issue_ready),
        .clr          (mdu_ready),
        .clr_reg      (mdu_reg),
        .rs           (dec_rs),
        .rt           (dec_rt),
        .rd           (dec_rd),
        .hazard       (hazard_stall),
        .probe_reg    (mdu_reg),
        .probe_pending(mdu_pending)
    );

    mdu_result_owed: assert property (@(posedge clk) disable iff (!rst_n)
        mdu_valid |-> (mdu_reg == ADDR_W'(REG_ZERO) || mdu_pending));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios plus randomized traffic checked against a per-cycle
// behavioural model of grants, starvation and the pending-register set.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_we;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic          wb_stall;
    logic          mdu_valid;
    logic [AW-1:0] mdu_reg;
    logic [DW-1:0] mdu_data;
    logic          mdu_ready;
    logic          issue_valid;
    logic [AW-1:0] issue_reg;
    logic          issue_ready;
    logic [AW-1:0] dec_rs;
    logic [AW-1:0] dec_rt;
    logic [AW-1:0] dec_rd;
    logic          hazard_stall;
    logic          rf_we;
    logic [AW-1:0] rf_wreg;
    logic [DW-1:0] rf_wdata;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .NREGS(32), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
        .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .hazard_stall(hazard_stall),
        .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: which registers are owed, how many cycles in a row the
    // offered MDU result has been refused, and the queue of outstanding MDU ops.
    bit            pend[32];
    int            starve;
    int            q[$];
    bit            chk_en;
    bit            e_mr, e_ws, e_ir, e_hz, e_we;
    logic [AW-1:0] e_reg;
    logic [DW-1:0] e_data;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit owed(input logic [AW-1:0] r);
        return (r != 0) && pend[r];
    endfunction

    function automatic void predict();
        bit forced;
        e_mr = 0; e_ws = 0; e_hz = 0; e_we = 0; e_reg = '0; e_data = '0;
        e_ir = issue_valid;
        if (rst_n) begin
            forced = (starve >= MW);
            e_mr = mdu_valid && (forced || !wb_we);
            e_ws = forced && wb_we;
            e_ir = issue_valid && (!pend[issue_reg] || (e_mr && mdu_reg == issue_reg));
            e_hz = owed(dec_rs) || owed(dec_rt) || owed(dec_rd);
            if (wb_we && !forced) begin
                e_we = (wb_reg != 0); e_reg = wb_reg; e_data = wb_data;
            end else if (e_mr) begin
                e_we = (mdu_reg != 0); e_reg = mdu_reg; e_data = mdu_data;
            end
        end
    endfunction

    function automatic void commit();
        bit done;
        if (!rst_n) begin
            foreach (pend[i]) pend[i] = 0;
            starve = 0;
            q.delete();
        end else begin
            if (e_mr) begin
                pend[mdu_reg] = 0;
                starve = 0;
                done = 0;
                for (int i = 0; i < q.size(); i++) begin
                    if (!done && q[i] == int'(mdu_reg)) begin
                        q.delete(i);
                        done = 1;
                    end
                end
            end else if (!mdu_valid) begin
                starve = 0;
            end else if (starve < MW) begin
                starve++;
            end
            if (e_ir && issue_reg != 0) begin
                pend[issue_reg] = 1;
                q.push_back(int'(issue_reg));
            end
        end
    endfunction

    task automatic half();
        @(negedge clk);
        predict();
        if (chk_en) begin
            expect_eq("wb_stall", wb_stall, e_ws);
            expect_eq("mdu_ready", mdu_ready, e_mr);
            expect_eq("issue_ready", issue_ready, e_ir);
            expect_eq("hazard_stall", hazard_stall, e_hz);
            expect_eq("rf_we", rf_we, e_we);
            expect_eq("rf_wreg", rf_wreg, e_reg);
            expect_eq("rf_wdata", rf_wdata, e_data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic cycle();
        half();
        tick();
    endtask

    task automatic starve_run(input logic [AW-1:0] r);
        issue_valid = 1; issue_reg = r;
        cycle();
        issue_valid = 0;
        wb_we = 1; wb_reg = 5'd4; mdu_valid = 1; mdu_reg = r; mdu_data = 32'hCC;
        for (int i = 0; i < MW; i++) begin
            wb_data = 32'(i + 1);
            half();
            expect_eq("starve_wb_wins", rf_wreg, 5'd4);
            expect_eq("starve_mdu_refused", mdu_ready, 1'b0);
            tick();
        end
        half();
        expect_eq("force_mdu_ready", mdu_ready, 1'b1);
        expect_eq("force_wb_stall", wb_stall, 1'b1);
        expect_eq("force_wdata", rf_wdata, 32'hCC);
        tick();
        mdu_valid = 0;
        half();
        expect_eq("wb_resumes_we", rf_we, 1'b1);
        expect_eq("wb_resumes_stall", wb_stall, 1'b0);
        tick();
        wb_we = 0;
    endtask

    initial begin
        rst_n = 0; wb_we = 0; wb_reg = '0; wb_data = '0;
        mdu_valid = 0; mdu_reg = '0; mdu_data = '0;
        issue_valid = 0; issue_reg = '0; dec_rs = '0; dec_rt = '0; dec_rd = '0;
        starve = 0; chk_en = 0;
        foreach (pend[i]) pend[i] = 0;
        #1;
        cycle();

        // Reset with every request asserted.
        chk_en = 1;
        wb_we = 1; wb_reg = 5'd3; wb_data = 32'h1234;
        mdu_valid = 1; mdu_reg = 5'd5; mdu_data = 32'h77;
        issue_valid = 1; issue_reg = 5'd7; dec_rs = 5'd1; dec_rt = 5'd2; dec_rd = 5'd3;
        half();
        expect_eq("rst_rf_we", rf_we, 1'b0);
        expect_eq("rst_mdu_ready", mdu_ready, 1'b0);
        expect_eq("rst_issue_ready", issue_ready, 1'b1);
        tick();
        rst_n = 1; mdu_valid = 0; issue_valid = 0; wb_we = 0;
        dec_rs = '0; dec_rt = '0; dec_rd = '0;

        // WB-only writes, including the zero register.
        wb_we = 1; wb_reg = 5'd8; wb_data = 32'h55;
        half();
        expect_eq("wb8_we", rf_we, 1'b1);
        expect_eq("wb8_wreg", rf_wreg, 5'd8);
        expect_eq("wb8_wdata", rf_wdata, 32'h55);
        tick();
        wb_reg = 5'd0;
        half();
        expect_eq("wb0_we", rf_we, 1'b0);
        expect_eq("wb0_stall", wb_stall, 1'b0);
        tick();
        wb_we = 0;

        // Issue 9, hazard on it, MDU writeback, hazard clears a cycle later.
        issue_valid = 1; issue_reg = 5'd9;
        cycle();
        issue_valid = 0; dec_rs = 5'd9;
        half();
        expect_eq("haz9_set", hazard_stall, 1'b1);
        tick();
        mdu_valid = 1; mdu_reg = 5'd9; mdu_data = 32'hAB;
        half();
        expect_eq("mdu9_ready", mdu_ready, 1'b1);
        expect_eq("mdu9_wdata", rf_wdata, 32'hAB);
        expect_eq("haz9_write_cycle", hazard_stall, 1'b1);
        tick();
        mdu_valid = 0;
        half();
        expect_eq("haz9_cleared", hazard_stall, 1'b0);
        tick();
        dec_rs = '0;

        starve_run(5'd11);

        // Same-cycle clear and re-issue of register 10.
        issue_valid = 1; issue_reg = 5'd10;
        cycle();
        mdu_valid = 1; mdu_reg = 5'd10; mdu_data = 32'h10;
        cycle();
        mdu_valid = 0; dec_rs = 5'd10;
        half();
        expect_eq("reissue10_refused", issue_ready, 1'b0);
        expect_eq("pend10_kept", hazard_stall, 1'b1);
        tick();
        issue_valid = 0; dec_rs = '0;

        // Reset with {9,10} owed and three refusals accumulated.
        issue_valid = 1; issue_reg = 5'd9;
        cycle();
        issue_valid = 0;
        wb_we = 1; wb_reg = 5'd2; mdu_valid = 1; mdu_reg = 5'd9;
        for (int i = 0; i < 3; i++) cycle();
        rst_n = 0;
        cycle();
        rst_n = 1; wb_we = 0; mdu_valid = 0; dec_rs = 5'd9; dec_rt = 5'd10;
        half();
        expect_eq("rst_mid_pend_dropped", hazard_stall, 1'b0);
        tick();
        dec_rs = '0; dec_rt = '0;
        starve_run(5'd12);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bit hold_wb;
            bit hold_mdu;
            hold_wb  = rst_n && wb_we && e_ws;
            hold_mdu = rst_n && mdu_valid && !e_mr;
            rst_n = ($urandom_range(0, 299) != 0);
            if (!hold_wb) begin
                wb_we = 1'($urandom_range(0, 1));
                wb_reg = 5'($urandom_range(0, 31));
                wb_data = $urandom;
            end
            if (!hold_mdu) begin
                if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                    mdu_valid = 1; mdu_reg = 5'(q[0]); mdu_data = $urandom;
                end else begin
                    mdu_valid = 0;
                end
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_reg = 5'($urandom_range(0, 15));
            dec_rs = 5'($urandom_range(0, 15));
            dec_rt = 5'($urandom_range(0, 15));
            dec_rd = 5'($urandom_range(0, 15));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
